// File: rtl/note_sprite_scheduler_if.sv
// Bus bundle between the staff renderer timing/slot table and the note sprite
// scheduler: line timing, the slot table, the shared glyph ROM port and status.
interface note_sprite_scheduler_if #(
  parameter int NUM_SLOTS = 8
);
  logic                      line_start;
  logic [9:0]                hcount;
  logic [9:0]                vcount;
  logic [NUM_SLOTS-1:0]      slot_valid;
  logic [10*NUM_SLOTS-1:0]   slot_x;
  logic [10*NUM_SLOTS-1:0]   slot_y;
  logic [2*NUM_SLOTS-1:0]    slot_type;
  logic [9:0]                rom_addr;
  logic [1:0]                rom_sel;
  logic                      rom_pixel;
  logic                      pixel_on;
  logic                      busy;
  logic                      overflow;

  // Renderer side: drives timing, slot table and the muxed ROM data.
  modport master (
    output line_start, hcount, vcount, slot_valid, slot_x, slot_y, slot_type, rom_pixel,
    input  rom_addr, rom_sel, pixel_on, busy, overflow
  );

  // Scheduler side.
  modport slave (
    input  line_start, hcount, vcount, slot_valid, slot_x, slot_y, slot_type, rom_pixel,
    output rom_addr, rom_sel, pixel_on, busy, overflow
  );
endinterface

// File: rtl/note_sprite_scheduler.sv
// Note sprite scheduler: at each line start scans the slot table (one slot per
// cycle) and latches up to MAX_ACTIVE slots covering the next line; during the
// line it picks the lowest covering entry per pixel, drives the shared glyph ROM
// address/select and returns pixel_on aligned to hcount + 2.
module note_sprite_scheduler #(
  parameter int NUM_SLOTS  = 8,
  parameter int MAX_ACTIVE = 4,
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 30,
  parameter int V_TOTAL    = 525
) (
  input  logic                   clk,
  input  logic                   reset,
  note_sprite_scheduler_if.slave bus
);
  localparam int KW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CW = $clog2(MAX_ACTIVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LINE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [9:0]      yn_q, yn_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  // Active list: entry i valid, left column, glyph type, glyph row.
  logic [MAX_ACTIVE-1:0] ent_v_q, ent_v_d;
  logic [9:0]            ent_x_q [MAX_ACTIVE];
  logic [9:0]            ent_x_d [MAX_ACTIVE];
  logic [1:0]            ent_t_q [MAX_ACTIVE];
  logic [1:0]            ent_t_d [MAX_ACTIVE];
  logic [RW-1:0]         ent_r_q [MAX_ACTIVE];
  logic [RW-1:0]         ent_r_d [MAX_ACTIVE];

  // Pixel pipeline registers.
  logic       hit1_q, hit1_d;
  logic       hit2_q;
  logic [9:0] rom_addr_q, rom_addr_d;
  logic [1:0] rom_sel_q, rom_sel_d;

  // Per-slot views of the flat slot buses.
  logic [9:0] slot_x_a [NUM_SLOTS];
  logic [9:0] slot_y_a [NUM_SLOTS];
  logic [1:0] slot_t_a [NUM_SLOTS];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign slot_x_a[gi] = bus.slot_x[10*gi +: 10];
      assign slot_y_a[gi] = bus.slot_y[10*gi +: 10];
      assign slot_t_a[gi] = bus.slot_type[2*gi +: 2];
    end
  endgenerate

  // Row of slot k within its glyph for the latched next line; a slot below the
  // line wraps to a large unsigned value and is rejected by the same compare.
  logic [10:0] scan_r;
  logic        scan_hit;
  logic [9:0]  yn_next;

  assign scan_r   = {1'b0, yn_q} - {1'b0, slot_y_a[k_q]};
  assign scan_hit = bus.slot_valid[k_q] && (scan_r < 11'(SPR_H));
  assign yn_next  = (bus.vcount == 10'(V_TOTAL - 1)) ? 10'd0 : bus.vcount + 10'd1;

  // Next-state logic: line_start always (re)starts a clean scan; SCAN walks the
  // table appending hits in slot order and flags hits that find the list full.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    yn_d    = yn_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ent_v_d = ent_v_q;
    for (int i = 0; i < MAX_ACTIVE; i++) begin
      ent_x_d[i] = ent_x_q[i];
      ent_t_d[i] = ent_t_q[i];
      ent_r_d[i] = ent_r_q[i];
    end

    if (bus.line_start) begin
      state_d = S_SCAN;
      k_d     = '0;
      yn_d    = yn_next;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      ent_v_d = '0;
    end else begin
      case (state_q)
        S_SCAN: begin
          if (scan_hit) begin
            if (cnt_q < CW'(MAX_ACTIVE)) begin
              for (int i = 0; i < MAX_ACTIVE; i++) begin
                if (cnt_q == CW'(i)) begin
                  ent_v_d[i] = 1'b1;
                  ent_x_d[i] = slot_x_a[k_q];
                  ent_t_d[i] = slot_t_a[k_q];
                  ent_r_d[i] = scan_r[RW-1:0];
                end
              end
              cnt_d = cnt_q + CW'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (k_q == KW'(NUM_SLOTS - 1)) begin
            state_d = S_LINE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // FSM and active-list state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      yn_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ent_v_q <= '0;
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        ent_x_q[i] <= '0;
        ent_t_q[i] <= '0;
        ent_r_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      yn_q    <= yn_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ent_v_q <= ent_v_d;
      for (int i = 0; i < MAX_ACTIVE; i++) begin
        ent_x_q[i] <= ent_x_d[i];
        ent_t_q[i] <= ent_t_d[i];
        ent_r_q[i] <= ent_r_d[i];
      end
    end
  end

  // Column coverage per entry; the right edge is formed in 11 bits so a glyph
  // near column 1023 clips instead of wrapping onto column 0.
  logic [MAX_ACTIVE-1:0] col_hit;

  generate
    for (genvar gi = 0; gi < MAX_ACTIVE; gi++) begin : g_col
      assign col_hit[gi] = ent_v_q[gi] &&
                           (ent_x_q[gi] <= bus.hcount) &&
                           ({1'b0, bus.hcount} < ({1'b0, ent_x_q[gi]} + 11'(SPR_W)));
    end
  endgenerate

  logic          pick_found;
  logic [9:0]    pick_x;
  logic [1:0]    pick_t;
  logic [RW-1:0] pick_r;
  logic [10:0]   pix_off;
  logic [10:0]   pix_addr;

  // Stage 1 select: lowest covering entry wins; address holds when nothing covers.
  always_comb begin
    pick_found = 1'b0;
    pick_x     = '0;
    pick_t     = '0;
    pick_r     = '0;
    for (int i = MAX_ACTIVE - 1; i >= 0; i--) begin
      if (col_hit[i]) begin
        pick_found = 1'b1;
        pick_x     = ent_x_q[i];
        pick_t     = ent_t_q[i];
        pick_r     = ent_r_q[i];
      end
    end
    pix_off    = {1'b0, bus.hcount} - {1'b0, pick_x};
    pix_addr   = 11'(pick_r) * 11'(SPR_W) + pix_off;
    hit1_d     = (state_q == S_LINE) && pick_found;
    rom_addr_d = hit1_d ? pix_addr[9:0] : rom_addr_q;
    rom_sel_d  = hit1_d ? pick_t : rom_sel_q;
  end

  // Pixel pipeline: stage-1 address/hit, then hit delayed to line up with ROM data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
    end else begin
      hit1_q     <= hit1_d;
      hit2_q     <= hit1_q;
      rom_addr_q <= rom_addr_d;
      rom_sel_q  <= rom_sel_d;
    end
  end

  // The ROM registers the address, so its data and hit2 both belong to hcount-2.
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_sel  = rom_sel_q;
  assign bus.pixel_on = hit2_q & bus.rom_pixel;
  assign bus.busy     = (state_q == S_SCAN);
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_note_sprite_scheduler.sv
// Self-checking bench for note_sprite_scheduler: directed scenarios plus
// randomized slot tables compared against a list/arithmetic reference model.
module tb_note_sprite_scheduler;
  localparam int NS = 8;
  localparam int MA = 4;
  localparam int SW = 20;
  localparam int SH = 30;
  localparam int VT = 525;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  note_sprite_scheduler_if #(.NUM_SLOTS(NS)) bus ();

  note_sprite_scheduler #(
    .NUM_SLOTS(NS), .MAX_ACTIVE(MA), .SPR_W(SW), .SPR_H(SH), .V_TOTAL(VT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Glyph ROMs: registered read, 1 cycle after the address.
  bit rom [4][SW*SH];
  always @(posedge clk) begin
    if (int'(bus.rom_addr) < SW*SH) bus.rom_pixel <= rom[int'(bus.rom_sel)][int'(bus.rom_addr)];
    else                            bus.rom_pixel <= 1'b0;
  end

  int checks = 0;
  int errors = 0;

  // Slot table as seen by the bench.
  bit s_v [NS];
  int s_x [NS];
  int s_y [NS];
  int s_t [NS];

  // Reference list for the current line.
  int m_n;
  bit m_ovf;
  int m_x [MA];
  int m_t [MA];
  int m_r [MA];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_slots();
    for (int i = 0; i < NS; i++) begin
      bus.slot_valid[i]        = s_v[i];
      bus.slot_x[10*i +: 10]   = 10'(s_x[i]);
      bus.slot_y[10*i +: 10]   = 10'(s_y[i]);
      bus.slot_type[2*i +: 2]  = 2'(s_t[i]);
    end
  endtask

  task automatic clear_slots();
    for (int i = 0; i < NS; i++) begin
      s_v[i] = 1'b0; s_x[i] = 0; s_y[i] = 0; s_t[i] = 0;
    end
  endtask

  task automatic model_scan(input int vc);
    int yn;
    int r;
    yn = (vc == VT - 1) ? 0 : vc + 1;
    m_n = 0;
    m_ovf = 1'b0;
    for (int k = 0; k < NS; k++) begin
      r = yn - s_y[k];
      if (s_v[k] && r >= 0 && r < SH) begin
        if (m_n < MA) begin
          m_x[m_n] = s_x[k]; m_t[m_n] = s_t[k]; m_r[m_n] = r;
          m_n++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic model_pix(input int h, output bit hit, output int addr, output int sel);
    hit = 1'b0; addr = 0; sel = 0;
    for (int e = 0; e < m_n; e++) begin
      if (!hit && h >= m_x[e] && h < m_x[e] + SW) begin
        hit = 1'b1; addr = m_r[e] * SW + (h - m_x[e]); sel = m_t[e];
      end
    end
  endtask

  // Start a scan at vcount vc; optionally pulse line_start again on the
  // restart_at-th busy cycle. Checks busy length and the overflow flag.
  task automatic do_scan(input int vc, input int restart_at, input string tag);
    int n;
    int exp_n;
    bus.vcount = 10'(vc);
    bus.line_start = 1'b1;
    tick();
    bus.line_start = 1'b0;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      if (n == restart_at) bus.line_start = 1'b1;
      tick();
      bus.line_start = 1'b0;
    end
    model_scan(vc);
    exp_n = (restart_at > 0) ? restart_at + NS : NS;
    checks++;
    if (n !== exp_n) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d expected %0d", tag, n, exp_n);
    end
    checks++;
    if (bus.overflow !== m_ovf) begin
      errors++;
      $display("FAIL %s overflow got %0b expected %0b", tag, bus.overflow, m_ovf);
    end
    $display("scan %s vcount=%0d entries=%0d overflow=%0b busy_cycles=%0d", tag, vc, m_n, m_ovf, n);
  endtask

  // Sweep hcount from h0 for len pixels, checking ROM address/select one cycle
  // later (held when uncovered) and pixel_on two cycles later.
  task automatic run_line(input int h0, input int len, input string tag);
    int h, a, s, last_a, last_s, pix_hits;
    bit hit, last_v, exp_p;
    last_v = 1'b0; last_a = 0; last_s = 0; pix_hits = 0;
    for (int c = 0; c < len + 2; c++) begin
      if (c >= 1 && c - 1 < len) begin
        h = (h0 + c - 1) % 1024;
        model_pix(h, hit, a, s);
        if (hit) begin last_v = 1'b1; last_a = a; last_s = s; end
        if (last_v) begin
          checks++;
          if (bus.rom_addr !== 10'(last_a) || bus.rom_sel !== 2'(last_s)) begin
            errors++;
            $display("FAIL %s rom h=%0d addr=%0d sel=%0d expected addr=%0d sel=%0d",
                     tag, h, bus.rom_addr, bus.rom_sel, last_a, last_s);
          end
        end
      end
      if (c >= 2) begin
        h = (h0 + c - 2) % 1024;
        model_pix(h, hit, a, s);
        exp_p = hit ? rom[s][a] : 1'b0;
        if (exp_p) pix_hits++;
        checks++;
        if (bus.pixel_on !== exp_p) begin
          errors++;
          $display("FAIL %s pixel_on h=%0d got %0b expected %0b", tag, h, bus.pixel_on, exp_p);
        end
      end
      bus.hcount = (c < len) ? 10'((h0 + c) % 1024) : 10'd1023;
      tick();
    end
    $display("line %s h0=%0d len=%0d lit_pixels=%0d", tag, h0, len, pix_hits);
  endtask

  task automatic setup_five();
    clear_slots();
    for (int i = 0; i < 5; i++) begin
      s_v[i] = 1'b1; s_x[i] = 50 + 30 * i; s_y[i] = 40 - 5 * i; s_t[i] = i % 4;
    end
    apply_slots();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.line_start = 1'b0; bus.hcount = 10'd1023; bus.vcount = '0;
    clear_slots(); apply_slots();
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.overflow, bus.pixel_on, bus.rom_sel, bus.rom_addr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b ovf=%0b pix=%0b sel=%0d addr=%0d expected all 0",
               bus.busy, bus.overflow, bus.pixel_on, bus.rom_sel, bus.rom_addr);
    end
    reset = 1'b0;
    tick();
    // Reset in the middle of a line with overflow set.
    setup_five();
    do_scan(39, 0, "pre_reset");
    bus.hcount = 10'd55; tick(); bus.hcount = 10'd56; tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.overflow, bus.pixel_on, bus.rom_sel, bus.rom_addr} !== 15'd0) begin
      errors++;
      $display("FAIL reset_midline got busy=%0b ovf=%0b pix=%0b sel=%0d addr=%0d expected all 0",
               bus.busy, bus.overflow, bus.pixel_on, bus.rom_sel, bus.rom_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    // Reset in the middle of a scan (slot k=3 being examined).
    bus.vcount = 10'd39; bus.line_start = 1'b1; tick(); bus.line_start = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_prescan busy got %0b expected 1", bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.overflow, bus.pixel_on} !== 3'b000) begin
      errors++;
      $display("FAIL reset_midscan got busy=%0b ovf=%0b pix=%0b expected 0",
               bus.busy, bus.overflow, bus.pixel_on);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.hcount = 10'(50 + i);
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.pixel_on !== 1'b0 || bus.rom_addr !== 10'd0) begin
        errors++;
        $display("FAIL reset_idle cycle=%0d busy=%0b pix=%0b addr=%0d expected 0 0 0",
                 i, bus.busy, bus.pixel_on, bus.rom_addr);
      end
    end
    $display("reset sequence done");
  endtask

  task automatic test_single();
    clear_slots();
    s_v[0] = 1'b1; s_x[0] = 100; s_y[0] = 50; s_t[0] = 1;
    // Invalid slots that would otherwise cover the line.
    s_x[3] = 105; s_y[3] = 45; s_t[3] = 2;
    s_x[5] = 130; s_y[5] = 50; s_t[5] = 3;
    apply_slots();
    do_scan(49, 0, "single");
    run_line(95, 40, "single");
  endtask

  task automatic test_overlap();
    clear_slots();
    s_v[0] = 1'b1; s_x[0] = 200; s_y[0] = 0; s_t[0] = 0;
    s_v[2] = 1'b1; s_x[2] = 200; s_y[2] = 0; s_t[2] = 2;
    apply_slots();
    do_scan(9, 0, "overlap");
    run_line(195, 30, "overlap");
  endtask

  task automatic test_overflow();
    setup_five();
    do_scan(39, 0, "overflow5");
    run_line(40, 170, "overflow5");
    s_v[3] = 1'b0; s_v[4] = 1'b0;
    apply_slots();
    do_scan(39, 0, "overflow3");
    run_line(40, 170, "overflow3");
  endtask

  task automatic test_wrap();
    clear_slots();
    s_v[0] = 1'b1; s_x[0] = 300; s_y[0] = 0;    s_t[0] = 3;
    s_v[1] = 1'b1; s_x[1] = 340; s_y[1] = 1000; s_t[1] = 1;
    apply_slots();
    do_scan(524, 0, "wrap_top");
    run_line(295, 70, "wrap_top");
    s_y[0] = 500;
    apply_slots();
    do_scan(528, 0, "row29");
    run_line(295, 30, "row29");
    do_scan(529, 0, "row30");
    run_line(295, 30, "row30");
  endtask

  task automatic test_clip();
    clear_slots();
    s_v[0] = 1'b1; s_x[0] = 1015; s_y[0] = 100; s_t[0] = 2;
    apply_slots();
    do_scan(99, 0, "clip");
    run_line(1005, 30, "clip");
  endtask

  task automatic test_back_to_back();
    clear_slots();
    for (int i = 1; i < NS; i += 2) begin
      s_v[i] = 1'b1; s_x[i] = 60 * i; s_y[i] = 70 - i; s_t[i] = i % 4;
    end
    s_v[4] = 1'b1; s_x[4] = 500; s_y[4] = 66; s_t[4] = 2;
    s_v[7] = 1'b0;
    apply_slots();
    do_scan(79, 6, "restart");
    run_line(0, 560, "restart");
  endtask

  task automatic test_random();
    int vc, yn, rs;
    for (int it = 0; it < 10; it++) begin
      vc = $urandom_range(0, VT - 1);
      yn = (vc == VT - 1) ? 0 : vc + 1;
      for (int i = 0; i < NS; i++) begin
        s_v[i] = ($urandom_range(0, 3) != 0);
        s_y[i] = (yn + 1024 - $urandom_range(0, 45)) % 1024;
        s_x[i] = $urandom_range(0, 620);
        s_t[i] = $urandom_range(0, 3);
      end
      apply_slots();
      rs = (it % 3 == 0) ? $urandom_range(1, NS) : 0;
      do_scan(vc, rs, "random");
      // Table changes during the line must not affect it.
      for (int i = 0; i < NS; i++) begin
        s_v[i] = $urandom_range(0, 1); s_x[i] = $urandom_range(0, 620);
        s_y[i] = yn; s_t[i] = $urandom_range(0, 3);
      end
      apply_slots();
      run_line(0, 640, "random");
    end
  endtask

  initial begin
    for (int g = 0; g < 4; g++)
      for (int p = 0; p < SW * SH; p++)
        rom[g][p] = 1'($urandom_range(0, 1));
    test_reset();
    test_single();
    test_overlap();
    test_overflow();
    test_wrap();
    test_clip();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
